// File: rtl/rgw_regfile_sb.sv
// rgw_regfile_sb: ID-stage register file with two combinational read ports,
// one write port and a per-register busy scoreboard for RAW hazard detection.
// Optional build macro: RGW_REGFILE_BYPASS_EN enables same-cycle write-through
// on both read ports. Without it, reads see only registered state.
//
// Issue/writeback semantics: there is no back-pressure. IssueValid marks
// IssueRegister busy at the next rising edge. RegWrite stores WriteData and
// clears the busy bit of WriteRegister at the same edge. Both are accepted
// every cycle. When both target one register, the issue wins and the
// register stays busy, because a newer producer is in flight.
module rgw_regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  IssueValid,
  input  logic [ADDR_WIDTH-1:0] IssueRegister,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Busy1,
  output logic                  Busy2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit ZeroEn   = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busyNext;
  logic                  wrEn;
  logic                  issueEn;

  // Writes and issues to the hardwired zero register are dropped here,
  // so neither storage nor the scoreboard ever sees them.
  always_comb begin
    wrEn    = RegWrite;
    issueEn = IssueValid;
    if (ZeroEn && (WriteRegister == '0)) wrEn = 1'b0;
    if (ZeroEn && (IssueRegister == '0)) issueEn = 1'b0;
  end

  // Storage: asynchronous clear; otherwise a single write per rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Scoreboard next state: the writeback clear is applied first and the
  // issue set second, so a set on the same register overrides the clear.
  always_comb begin
    busyNext = busy;
    if (wrEn) busyNext[WriteRegister] = 1'b0;
    if (issueEn) busyNext[IssueRegister] = 1'b1;
    if (ZeroEn) busyNext[0] = 1'b0;
  end

  // Scoreboard state: asynchronous clear drops every pending producer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busyNext;
  end

  // Read port 1: registered data and busy, optional write-through, zero override last.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    Busy1     = busy[ReadRegister1];
`ifdef RGW_REGFILE_BYPASS_EN
    if (wrEn && (WriteRegister == ReadRegister1)) begin
      ReadData1 = WriteData;
      Busy1     = issueEn && (IssueRegister == ReadRegister1);
    end
`endif
    if (ZeroEn && (ReadRegister1 == '0)) begin
      ReadData1 = '0;
      Busy1     = 1'b0;
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    ReadData2 = regs[ReadRegister2];
    Busy2     = busy[ReadRegister2];
`ifdef RGW_REGFILE_BYPASS_EN
    if (wrEn && (WriteRegister == ReadRegister2)) begin
      ReadData2 = WriteData;
      Busy2     = issueEn && (IssueRegister == ReadRegister2);
    end
`endif
    if (ZeroEn && (ReadRegister2 == '0)) begin
      ReadData2 = '0;
      Busy2     = 1'b0;
    end
  end

endmodule

// File: doc/rgw_regfile_sb.md
Name: rgw_regfile_sb

Overview:
Parametrised register file with two read ports and one write port, plus a per-register busy scoreboard. It is the next generation of the ID-stage register file.
- Adds an asynchronous clear of all storage.
- Optional register-zero hardwiring.
- Issue/writeback busy tracking, so the ID stage detects RAW hazards against in-flight producers.
- Optional write-to-read bypass.

Parameters:
DATA_WIDTH, 32, width of each register and data ports
ADDR_WIDTH, 5, register index width; register count NUM_REGS = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
RegWrite  input  1  writeback strobe
WriteRegister  input  ADDR_WIDTH  writeback destination index
WriteData  input  DATA_WIDTH  writeback data
IssueValid  input  1  an instruction with a destination is issuing this cycle
IssueRegister  input  ADDR_WIDTH  destination index of issuing instruction
ReadRegister1  input  ADDR_WIDTH  read port 1 index
ReadRegister2  input  ADDR_WIDTH  read port 2 index
ReadData1  output  DATA_WIDTH  read port 1 data (combinational)
ReadData2  output  DATA_WIDTH  read port 2 data (combinational)
Busy1  output  1  register at ReadRegister1 has a pending producer
Busy2  output  1  register at ReadRegister2 has a pending producer

Behaviour:
- Reset: while rst=1, asynchronously clear all NUM_REGS data registers and busy bits to 0. ReadDataN = 0 and BusyN = 0 during and immediately after reset. Reset mid-operation discards pending busy state and any same-cycle write.
- Storage write: on posedge clk, if RegWrite, regs[WriteRegister] <= WriteData.
  - With ZERO_REG=1 and WriteRegister=0, no write occurs.
- Reads: ReadDataN = regs[ReadRegisterN], combinational, no added latency.
  - With ZERO_REG=1 and index 0, the output is forced to 0.
  - Without bypass, a write becomes visible on the cycle after its clock edge.
- Scoreboard: one busy bit per register. Next-state rules, evaluated per register r on posedge clk:
  - Set when IssueValid and IssueRegister==r.
  - Clear when RegWrite and WriteRegister==r.
  - Set and clear on the same r in the same cycle: set wins (a newer producer is in flight).
  - Issue and write to different registers: both take effect independently.
  - With ZERO_REG=1, busy[0] is held at 0 and issue to register 0 is ignored.
- BusyN = busy[ReadRegisterN] (combinational from registered state). Writeback to an already-clear register leaves it clear; this is not an error.
- Both read ports may address the same register; they return identical data and busy values.
- No handshake back-pressure: the block always accepts issue and writeback in every cycle.

Optional Feature:
Macro RGW_REGFILE_BYPASS_EN.
- Defined: same-cycle write-through. When RegWrite=1 and WriteRegister==ReadRegisterN (and not the hardwired zero register), ReadDataN = WriteData combinationally. BusyN = 0 for that port unless IssueValid targets the same register in that cycle, in which case BusyN = 1.
- Undefined: reads see only registered contents. BusyN reflects registered busy only, so the consumer sees the writeback one cycle later (a one-cycle hazard window handled by the pipeline).
- Storage and scoreboard next-state logic are identical in both builds.

Test Plan:
- Assert rst=1 asynchronously mid-cycle after writing 0xDEADBEEF to r5 and issuing r7 -> ReadData1=0 for r5, Busy for r7=0, immediately and without a clock edge.
- Write r3=0x12345678 with RegWrite=1; read r3 on both ports next cycle -> both ReadData=0x12345678. Write r0=0xFFFFFFFF with ZERO_REG=1 -> ReadData1=0. Repeat with ZERO_REG=0 -> 0xFFFFFFFF.
- Issue r9 at cycle 1 -> Busy1=1 from cycle 2 with ReadRegister1=9. Writeback r9=0xA5A5A5A5 at cycle 4 -> Busy1=0 and ReadData1=0xA5A5A5A5 at cycle 5.
- Issue r4 and writeback r4 in the same cycle -> busy[4]=1 afterwards. Issue r4 and writeback r6 in the same cycle -> busy[4]=1, busy[6]=0.
- RGW_REGFILE_BYPASS_EN defined: RegWrite r12=0x0000BEEF with ReadRegister2=12 in the same cycle -> ReadData2=0x0000BEEF, Busy2=0 in that cycle. Undefined -> old value in that cycle, new value next cycle.
- Parameter sweep DATA_WIDTH=16, ADDR_WIDTH=3: write all 8 registers with index*0x1111, then read back -> exact values. Issue all 8 registers (r0 ignored with ZERO_REG=1) -> busy for r1..r7 only.
